// File: rtl/pbs_pkg.sv
// pbs_pkg: shared definitions for the battle sequencer.
//   pbs_state_e  : FSM state encodings (also exported on state_out)
//   pbs_result_e : battle outcome codes driven on result
//   HEAL_MAX     : heals available to the player per battle
//   sat_inc8     : saturating 8-bit increment used by the turn counter
package pbs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_P_WAIT     = 4'd1,
    ST_P_ATK_SET  = 4'd2,
    ST_P_ATK_APP  = 4'd3,
    ST_P_HEAL     = 4'd4,
    ST_P_CATCH    = 4'd5,
    ST_CHK_AI     = 4'd6,
    ST_AI_THINK   = 4'd7,
    ST_AI_ATK_SET = 4'd8,
    ST_AI_ATK_APP = 4'd9,
    ST_CHK_P      = 4'd10,
    ST_DONE       = 4'd11
  } pbs_state_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_WIN    = 2'd1,
    RES_LOSE   = 2'd2,
    RES_CAUGHT = 2'd3
  } pbs_result_e;

  localparam logic [1:0] HEAL_MAX = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pbs_edge_det.sv
// pbs_edge_det: single-flop rising-edge detector.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset (clears the history flop)
//   d    : level input
//   rise : high for the one cycle in which d is 1 and was 0 last cycle
module pbs_edge_det
  import pbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pbs_ctrl.sv
// pbs_ctrl: turn sequencer for a two-trainer battle.
//   clk, rst                      : clock, synchronous active-low reset
//   start                         : rising edge starts a battle / leaves DONE
//   btn_attack/heal/catch         : player buttons (levels, edge-detected)
//   move_sel                      : move index captured on an attack
//   ai_dead, p_dead, catch_success: datapath status
//   p_move, actr, target, stop    : datapath control levels
//   heal, catch, load_ai_hp,
//   app_ai_dmg, app_pl_dmg        : one-cycle strobes (mutually exclusive)
//   state_out, turn_cnt, game_over, result : status
//
// state         | meaning
// IDLE          | waiting for a start edge
// P_WAIT        | waiting for a player button edge
// P_ATK_SET     | player attack: datapath settles (RNG frozen)
// P_ATK_APP     | player attack: damage applied to AI
// P_HEAL        | heal strobe, one heal consumed
// P_CATCH       | catch strobe, catch_success sampled
// CHK_AI        | check whether the AI fainted
// AI_THINK      | RNGs run for AI_WAIT cycles
// AI_ATK_SET    | AI attack: datapath settles (RNG frozen)
// AI_ATK_APP    | AI attack: damage applied to player
// CHK_P         | check whether the player fainted, count the turn
// DONE          | battle over, result held
module pbs_ctrl
  import pbs_pkg::*;
#(
  parameter int AI_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_attack,
  input  logic       btn_heal,
  input  logic       btn_catch,
  input  logic [1:0] move_sel,
  input  logic       ai_dead,
  input  logic       p_dead,
  input  logic       catch_success,
  output logic [1:0] p_move,
  output logic       actr,
  output logic       target,
  output logic       heal,
  output logic       catch,
  output logic       stop,
  output logic       load_ai_hp,
  output logic       app_ai_dmg,
  output logic       app_pl_dmg,
  output logic [3:0] state_out,
  output logic [7:0] turn_cnt,
  output logic       game_over,
  output logic [1:0] result
);

  localparam logic [7:0] THINK_LOAD = 8'(AI_WAIT - 1);

  pbs_state_e  state_q, state_d;
  pbs_result_e result_q, res_val;
  logic [1:0]  p_move_q;
  logic [1:0]  heals_q;
  logic [7:0]  turn_q;
  logic [7:0]  think_q;
  logic        load_q;

  logic start_rise, atk_rise, heal_rise, catch_rise;
  logic new_battle, latch_move, use_heal, inc_turn, res_set;

  pbs_edge_det u_edge_start (.clk(clk), .rst(rst), .d(start),      .rise(start_rise));
  pbs_edge_det u_edge_atk   (.clk(clk), .rst(rst), .d(btn_attack), .rise(atk_rise));
  pbs_edge_det u_edge_heal  (.clk(clk), .rst(rst), .d(btn_heal),   .rise(heal_rise));
  pbs_edge_det u_edge_catch (.clk(clk), .rst(rst), .d(btn_catch),  .rise(catch_rise));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and register enables use the inputs; the outputs below decode
  // state_q only, so there is no input-to-output combinational path.
  always_comb begin
    state_d    = state_q;
    new_battle = 1'b0;
    latch_move = 1'b0;
    use_heal   = 1'b0;
    inc_turn   = 1'b0;
    res_set    = 1'b0;
    res_val    = RES_NONE;
    actr       = 1'b0;
    stop       = 1'b0;
    heal       = 1'b0;
    catch      = 1'b0;
    app_ai_dmg = 1'b0;
    app_pl_dmg = 1'b0;
    game_over  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_P_WAIT;
          new_battle = 1'b1;
        end
      end
      ST_P_WAIT: begin
        // A heal edge with no heals left swallows the whole cycle, including
        // any attack edge that arrived with it.
        if (catch_rise) begin
          state_d = ST_P_CATCH;
        end else if (heal_rise) begin
          if (heals_q != 2'd0) state_d = ST_P_HEAL;
        end else if (atk_rise) begin
          state_d    = ST_P_ATK_SET;
          latch_move = 1'b1;
        end
      end
      ST_P_ATK_SET: begin
        stop    = 1'b1;
        state_d = ST_P_ATK_APP;
      end
      ST_P_ATK_APP: begin
        stop       = 1'b1;
        app_ai_dmg = 1'b1;
        state_d    = ST_CHK_AI;
      end
      ST_P_HEAL: begin
        heal     = 1'b1;
        use_heal = 1'b1;
        state_d  = ST_AI_THINK;
      end
      ST_P_CATCH: begin
        catch = 1'b1;
        if (catch_success) begin
          state_d = ST_DONE;
          res_set = 1'b1;
          res_val = RES_CAUGHT;
        end else begin
          state_d = ST_AI_THINK;
        end
      end
      ST_CHK_AI: begin
        if (ai_dead) begin
          state_d = ST_DONE;
          res_set = 1'b1;
          res_val = RES_WIN;
        end else begin
          state_d = ST_AI_THINK;
        end
      end
      ST_AI_THINK: begin
        actr = 1'b1;
        if (think_q == 8'd0) state_d = ST_AI_ATK_SET;
      end
      ST_AI_ATK_SET: begin
        actr    = 1'b1;
        stop    = 1'b1;
        state_d = ST_AI_ATK_APP;
      end
      ST_AI_ATK_APP: begin
        actr       = 1'b1;
        stop       = 1'b1;
        app_pl_dmg = 1'b1;
        state_d    = ST_CHK_P;
      end
      ST_CHK_P: begin
        actr = 1'b1;
        if (p_dead) begin
          state_d = ST_DONE;
          res_set = 1'b1;
          res_val = RES_LOSE;
        end else begin
          state_d  = ST_P_WAIT;
          inc_turn = 1'b1;
        end
      end
      ST_DONE: begin
        game_over = 1'b1;
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // load_ai_hp is registered so it appears in the first P_WAIT cycle while
  // still coming from a flop rather than from the start input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_q   <= 1'b0;
      p_move_q <= 2'd0;
      heals_q  <= HEAL_MAX;
      turn_q   <= 8'd0;
      result_q <= RES_NONE;
    end else begin
      load_q <= new_battle;
      if (latch_move) p_move_q <= move_sel;
      if (new_battle)    heals_q <= HEAL_MAX;
      else if (use_heal) heals_q <= heals_q - 2'd1;
      if (new_battle)    turn_q <= 8'd0;
      else if (inc_turn) turn_q <= sat_inc8(turn_q);
      if (new_battle)    result_q <= RES_NONE;
      else if (res_set)  result_q <= res_val;
    end
  end

  // Think timer: preloaded while outside AI_THINK, counts down inside it and
  // releases the FSM at terminal count, giving exactly AI_WAIT think cycles.
  always_ff @(posedge clk) begin
    if (!rst)                           think_q <= 8'd0;
    else if (state_q != ST_AI_THINK)    think_q <= THINK_LOAD;
    else if (think_q != 8'd0)           think_q <= think_q - 8'd1;
  end

  assign target     = actr;
  assign load_ai_hp = load_q;
  assign p_move     = p_move_q;
  assign turn_cnt   = turn_q;
  assign result     = result_q;
  assign state_out  = state_q;

endmodule
